// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of requester handshakes and fifo write-side signals shared by the arbiter and its agents.
// The master modport is the arbiter's view; the slave modport is the requesters/fifo view.
interface fifo_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
) ();
  localparam int OW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       last;
  logic [NREQ*WIDTH-1:0] data;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_read;
  logic                  fifo_write;
  logic [WIDTH-1:0]      fifo_data_in;
  logic                  busy;
  logic [OW-1:0]         owner;

  modport master (
    input  req, last, data, fifo_full, fifo_empty, fifo_read,
    output gnt, ack, fifo_write, fifo_data_in, busy, owner
  );

  modport slave (
    output req, last, data, fifo_full, fifo_empty, fifo_read,
    input  gnt, ack, fifo_write, fifo_data_in, busy, owner
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one fifo write port among NREQ requesters.
// Writes are gated so the fifo never sees a write it would drop.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst_,
  fifo_wr_arbiter_if.master    bus
);
  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q, state_n;
  logic [NREQ-1:0] gnt_q, gnt_n;
  logic            busy_q, busy_n;
  logic [OW-1:0]   owner_q, owner_n;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_n;
  logic [OW-1:0]   rr_ptr_q, rr_ptr_n;

  logic            beat;
  logic            found;
  logic [OW-1:0]   sel;
  int              idx;

  // A simultaneous write and read on an empty fifo is dropped by the fifo, so it is not a beat.
  assign beat = busy_q & bus.req[owner_q] & ~bus.fifo_full & ~(bus.fifo_empty & bus.fifo_read);

  assign bus.gnt        = gnt_q;
  assign bus.busy       = busy_q;
  assign bus.owner      = owner_q;
  assign bus.fifo_write = beat;
  assign bus.fifo_data_in = busy_q ? bus.data[int'(owner_q)*WIDTH +: WIDTH] : '0;

  always_comb begin
    bus.ack          = '0;
    bus.ack[owner_q] = beat;
  end

  // Rotating priority: scan starts just after the last served requester.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        sel   = OW'(idx);
      end
    end
  end

  always_comb begin
    state_n    = state_q;
    gnt_n      = gnt_q;
    busy_n     = busy_q;
    owner_n    = owner_q;
    beat_cnt_n = beat_cnt_q;
    rr_ptr_n   = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_n    = BURST;
          gnt_n      = '0;
          gnt_n[sel] = 1'b1;
          owner_n    = sel;
          busy_n     = 1'b1;
          beat_cnt_n = '0;
        end
      end
      BURST: begin
        if (!bus.req[owner_q] ||
            (beat && (bus.last[owner_q] || (beat_cnt_q + CW'(1) == CW'(MAX_BURST))))) begin
          state_n  = IDLE;
          gnt_n    = '0;
          busy_n   = 1'b0;
          rr_ptr_n = owner_q;
        end
        if (beat) beat_cnt_n = beat_cnt_q + CW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      rr_ptr_q   <= OW'(NREQ - 1);
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q    <= state_n;
      gnt_q      <= gnt_n;
      busy_q     <= busy_n;
      owner_q    <= owner_n;
      beat_cnt_q <= beat_cnt_n;
      rr_ptr_q   <= rr_ptr_n;
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_) $onehot0(gnt_q));
  a_no_full_wr: assert property (@(posedge clk) disable iff (!rst_) bus.fifo_write |-> !bus.fifo_full);
  a_no_drop_wr: assert property (@(posedge clk) disable iff (!rst_)
                                 bus.fifo_write |-> !(bus.fifo_empty && bus.fifo_read));
  a_busy_gnt:   assert property (@(posedge clk) disable iff (!rst_) busy_q == (gnt_q != '0));
  a_cnt_range:  assert property (@(posedge clk) disable iff (!rst_) beat_cnt_q <= CW'(MAX_BURST));
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: each task drives one scenario and compares against hand-computed values.
// Inputs change and outputs are sampled 2 time units after the rising edge.
module tb_fifo_wr_arbiter;
  logic clk = 1'b0;
  logic rst_ = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic [15:0] exp_data [4] = '{16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3};

  fifo_wr_arbiter_if #(.NREQ(4), .WIDTH(16)) bus ();

  fifo_wr_arbiter #(.NREQ(4), .WIDTH(16), .MAX_BURST(4)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst_ = 1'b0;
    bus.req = '0; bus.last = '0;
    bus.fifo_full = 1'b0; bus.fifo_empty = 1'b0; bus.fifo_read = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_ = 1'b1;
  endtask

  task automatic test_reset;
    rst_ = 1'b0;
    bus.req = 4'b1111; bus.last = '0;
    bus.data = {16'hD3D3, 16'hC2C2, 16'hB1B1, 16'hA0A0};
    bus.fifo_full = 1'b0; bus.fifo_empty = 1'b0; bus.fifo_read = 1'b0;
    #1;
    tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL rst_gnt: got %b exp 0000", bus.gnt); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b exp 0", bus.busy); end
    tests++; if (bus.owner !== 2'd0) begin fails++; $display("FAIL rst_owner: got %0d exp 0", bus.owner); end
    tests++; if (bus.fifo_write !== 1'b0 || bus.ack !== 4'b0000) begin
      fails++; $display("FAIL rst_write_ack: got %b/%b exp 0/0000", bus.fifo_write, bus.ack);
    end
    tests++; if (bus.fifo_data_in !== 16'h0000) begin fails++; $display("FAIL rst_data: got %h exp 0000", bus.fifo_data_in); end
    tick;
    tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL rst_hold_gnt: got %b exp 0000", bus.gnt); end
    bus.req = '0;
    rst_ = 1'b1;
  endtask

  task automatic test_max_burst;
    bus.req = 4'b0001; bus.last = '0;
    #1;
    tests++; if (bus.gnt !== 4'b0000 || bus.fifo_write !== 1'b0) begin
      fails++; $display("FAIL maxb_idle: gnt %b write %b exp 0000/0", bus.gnt, bus.fifo_write);
    end
    tick;
    for (int b = 0; b < 4; b++) begin
      tests++; if (bus.gnt !== 4'b0001 || bus.fifo_write !== 1'b1 || bus.ack !== 4'b0001) begin
        fails++; $display("FAIL maxb_beat%0d: gnt %b write %b ack %b exp 0001/1/0001", b, bus.gnt, bus.fifo_write, bus.ack);
      end
      tests++; if (bus.fifo_data_in !== 16'hA0A0) begin
        fails++; $display("FAIL maxb_data%0d: got %h exp a0a0", b, bus.fifo_data_in);
      end
      tick;
    end
    tests++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.fifo_write !== 1'b0) begin
      fails++; $display("FAIL maxb_bubble: gnt %b busy %b write %b exp 0000/0/0", bus.gnt, bus.busy, bus.fifo_write);
    end
    tick;
    tests++; if (bus.gnt !== 4'b0001 || bus.owner !== 2'd0) begin
      fails++; $display("FAIL maxb_regrant: gnt %b owner %0d exp 0001/0", bus.gnt, bus.owner);
    end
    bus.req = '0;
    #1;
    tests++; if (bus.fifo_write !== 1'b0) begin fails++; $display("FAIL maxb_release: write %b exp 0", bus.fifo_write); end
    tick;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL maxb_release_idle: busy %b exp 0", bus.busy); end
  endtask

  task automatic test_round_robin;
    int writes;
    logic [3:0] eg;
    do_reset;
    writes = 0;
    bus.req = 4'b1111; bus.last = '0;
    for (int k = 0; k < 5; k++) begin
      int o;
      o = k % 4;
      eg = 4'b0001 << o;
      #1;
      tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL rr_bubble%0d: gnt %b exp 0000", k, bus.gnt); end
      if (bus.fifo_write === 1'b1) writes++;
      tick;
      for (int b = 0; b < 4; b++) begin
        tests++; if (bus.gnt !== eg || bus.owner !== o[1:0]) begin
          fails++; $display("FAIL rr_grant%0d_%0d: gnt %b owner %0d exp %b/%0d", k, b, bus.gnt, bus.owner, eg, o);
        end
        tests++; if (bus.fifo_data_in !== exp_data[o]) begin
          fails++; $display("FAIL rr_data%0d_%0d: got %h exp %h", k, b, bus.fifo_data_in, exp_data[o]);
        end
        if (bus.fifo_write === 1'b1) writes++;
        tick;
      end
    end
    tests++; if (writes !== 20) begin fails++; $display("FAIL rr_write_count: got %0d exp 20", writes); end
    bus.req = '0;
    tick;
  endtask

  task automatic test_last;
    bus.req = 4'b0010; bus.last = '0;
    tick;
    tests++; if (bus.gnt !== 4'b0010 || bus.fifo_write !== 1'b1) begin
      fails++; $display("FAIL last_beat1: gnt %b write %b exp 0010/1", bus.gnt, bus.fifo_write);
    end
    tick;
    bus.last = 4'b0010;
    #1;
    tests++; if (bus.fifo_write !== 1'b1 || bus.ack !== 4'b0010) begin
      fails++; $display("FAIL last_beat2: write %b ack %b exp 1/0010", bus.fifo_write, bus.ack);
    end
    tick;
    bus.last = '0;
    tests++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL last_end: gnt %b busy %b exp 0000/0", bus.gnt, bus.busy);
    end
    bus.req = 4'b0011;
    tick;
    tests++; if (bus.gnt !== 4'b0001 || bus.owner !== 2'd0) begin
      fails++; $display("FAIL last_priority: gnt %b owner %0d exp 0001/0", bus.gnt, bus.owner);
    end
    bus.req = '0;
    #1;
    tests++; if (bus.fifo_write !== 1'b0) begin fails++; $display("FAIL last_release: write %b exp 0", bus.fifo_write); end
    tick;
  endtask

  task automatic test_full_stall;
    bus.req = 4'b0100;
    tick;
    tests++; if (bus.gnt !== 4'b0100 || bus.fifo_write !== 1'b1) begin
      fails++; $display("FAIL full_beat1: gnt %b write %b exp 0100/1", bus.gnt, bus.fifo_write);
    end
    tick;
    for (int s = 0; s < 3; s++) begin
      bus.fifo_full = 1'b1;
      #1;
      tests++; if (bus.fifo_write !== 1'b0 || bus.ack !== 4'b0000 || bus.gnt !== 4'b0100) begin
        fails++; $display("FAIL full_stall%0d: write %b ack %b gnt %b exp 0/0000/0100", s, bus.fifo_write, bus.ack, bus.gnt);
      end
      tick;
    end
    bus.fifo_full = 1'b0;
    #1;
    for (int b = 0; b < 3; b++) begin
      tests++; if (bus.fifo_write !== 1'b1 || bus.owner !== 2'd2 || bus.fifo_data_in !== 16'hC2C2) begin
        fails++; $display("FAIL full_resume%0d: write %b owner %0d data %h exp 1/2/c2c2", b, bus.fifo_write, bus.owner, bus.fifo_data_in);
      end
      tick;
    end
    tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL full_total: gnt %b exp 0000 after 4 beats", bus.gnt); end
    bus.req = '0;
    tick;
  endtask

  task automatic test_empty_read;
    bus.req = 4'b1000;
    tick;
    tests++; if (bus.gnt !== 4'b1000) begin fails++; $display("FAIL er_grant: gnt %b exp 1000", bus.gnt); end
    bus.fifo_empty = 1'b1; bus.fifo_read = 1'b1;
    #1;
    tests++; if (bus.fifo_write !== 1'b0 || bus.ack !== 4'b0000) begin
      fails++; $display("FAIL er_block: write %b ack %b exp 0/0000", bus.fifo_write, bus.ack);
    end
    tick;
    bus.fifo_read = 1'b0;
    #1;
    tests++; if (bus.fifo_write !== 1'b1 || bus.ack !== 4'b1000) begin
      fails++; $display("FAIL er_empty_only: write %b ack %b exp 1/1000", bus.fifo_write, bus.ack);
    end
    tick;
    bus.fifo_empty = 1'b0; bus.fifo_read = 1'b1;
    #1;
    tests++; if (bus.fifo_write !== 1'b1) begin fails++; $display("FAIL er_read_only: write %b exp 1", bus.fifo_write); end
    tick;
    bus.fifo_read = 1'b0; bus.req = '0;
    #1;
    tests++; if (bus.fifo_write !== 1'b0) begin fails++; $display("FAIL er_release: write %b exp 0", bus.fifo_write); end
    tick;
  endtask

  task automatic test_reset_mid_burst;
    bus.req = 4'b0100;
    tick;
    for (int b = 0; b < 2; b++) begin
      tests++; if (bus.gnt !== 4'b0100 || bus.fifo_write !== 1'b1) begin
        fails++; $display("FAIL rmb_pre%0d: gnt %b write %b exp 0100/1", b, bus.gnt, bus.fifo_write);
      end
      tick;
    end
    rst_ = 1'b0;
    #1;
    tests++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL rmb_async: gnt %b busy %b exp 0000/0", bus.gnt, bus.busy);
    end
    tests++; if (bus.fifo_write !== 1'b0 || bus.ack !== 4'b0000 || bus.fifo_data_in !== 16'h0000) begin
      fails++; $display("FAIL rmb_async_out: write %b ack %b data %h exp 0/0000/0000", bus.fifo_write, bus.ack, bus.fifo_data_in);
    end
    tick;
    rst_ = 1'b1;
    #1;
    tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL rmb_post: gnt %b exp 0000", bus.gnt); end
    tick;
    for (int b = 0; b < 4; b++) begin
      tests++; if (bus.gnt !== 4'b0100 || bus.fifo_write !== 1'b1) begin
        fails++; $display("FAIL rmb_regrant%0d: gnt %b write %b exp 0100/1", b, bus.gnt, bus.fifo_write);
      end
      tick;
    end
    tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL rmb_full_burst: gnt %b exp 0000", bus.gnt); end
    bus.req = '0;
    tick;
  endtask

  initial begin
    test_reset;
    test_max_burst;
    test_round_robin;
    test_last;
    test_full_stall;
    test_empty_read;
    test_reset_mid_burst;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
